spc7110_rom_arbiter: RTL and testbench

//  Shares the single PSRAM read port among three data ROM requesters: SNES-triggered direct/MMIO

---
 rtl/spc7110_pkg.sv | 21 ++
 rtl/spc7110_rom_arbiter_if.sv | 35 +++
 rtl/spc7110_rom_prio.sv | 26 ++
 rtl/spc7110_rom_arbiter.sv | 141 ++++++++++++++
 tb/tb_spc7110_rom_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spc7110_pkg.sv
// Shared types for the SPC7110 data ROM arbiter: requester ownership and
// the read sequencer state encoding.
package spc7110_pkg;

   localparam int ADDR_W = 24;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_SNES = 2'd1,
      OWN_DCMP = 2'd2,
      OWN_MCU  = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/spc7110_rom_arbiter_if.sv
// Requester and PSRAM read-port bundle around the data ROM arbiter.
// slave is the arbiter's view; master is the requesters/PSRAM view.
interface spc7110_rom_arbiter_if #(
   parameter int ADDR_W = spc7110_pkg::ADDR_W
);
   logic              snes_rd;
   logic [ADDR_W-1:0] snes_addr;
   logic [7:0]        snes_data;
   logic              snes_busy;
   logic              snes_overrun;
   logic              dcmp_req;
   logic [ADDR_W-1:0] dcmp_addr;
   logic              dcmp_ack;
   logic [7:0]        dcmp_data;
   logic              mcu_req;
   logic [ADDR_W-1:0] mcu_addr;
   logic              mcu_ack;
   logic [7:0]        mcu_data;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data_in;

   modport slave (
      input  snes_rd, snes_addr, dcmp_req, dcmp_addr, mcu_req, mcu_addr, mem_data_in,
      output snes_data, snes_busy, snes_overrun, dcmp_ack, dcmp_data,
             mcu_ack, mcu_data, mem_rd, mem_addr
   );

   modport master (
      output snes_rd, snes_addr, dcmp_req, dcmp_addr, mcu_req, mcu_addr, mem_data_in,
      input  snes_data, snes_busy, snes_overrun, dcmp_ack, dcmp_data,
             mcu_ack, mcu_data, mem_rd, mem_addr
   );

endinterface

// File: rtl/spc7110_rom_prio.sv
// Combinational requester picker: SNES first, then MCU once the decompressor
// has used up its burst allowance, then decompressor, then MCU.
module spc7110_rom_prio
   import spc7110_pkg::*;
#(
   parameter int DCMP_BURST_MAX = 4,
   parameter int CNT_W          = $clog2(DCMP_BURST_MAX + 1)
) (
   input  logic [2:0]       pend,       // {snes, dcmp, mcu}
   input  logic [CNT_W-1:0] burst_cnt,
   output owner_e           owner
);

   always_comb begin
      owner = OWN_NONE;
      if (pend[2])
         owner = OWN_SNES;
      else if (pend[0] && (burst_cnt == CNT_W'(DCMP_BURST_MAX)))
         owner = OWN_MCU;
      else if (pend[1])
         owner = OWN_DCMP;
      else if (pend[0])
         owner = OWN_MCU;
   end

endmodule

// File: rtl/spc7110_rom_arbiter.sv
// Shares the single PSRAM read port among SNES, decompressor and MCU reads,
// running one fixed-latency read at a time: IDLE -> ISSUE -> WAIT -> DONE.
module spc7110_rom_arbiter
   import spc7110_pkg::*;
#(
   parameter int ADDR_W         = spc7110_pkg::ADDR_W,
   parameter int RD_CYCLES      = 4,
   parameter int DCMP_BURST_MAX = 4
) (
   input logic                  CLK,
   input logic                  RESET,
   spc7110_rom_arbiter_if.slave bus
);

   localparam int WAIT_W  = $clog2(RD_CYCLES);
   localparam int BURST_W = $clog2(DCMP_BURST_MAX + 1);

   state_e              state, state_nxt;
   owner_e              owner, pick;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [BURST_W-1:0]  burst_cnt;
   logic [ADDR_W-1:0]   snes_pend_addr;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                snes_busy_q, snes_issued, snes_overrun_q;
   logic [7:0]          snes_data_q, dcmp_data_q, mcu_data_q;
   logic                grant, capture;

   spc7110_rom_prio #(
      .DCMP_BURST_MAX (DCMP_BURST_MAX),
      .CNT_W          (BURST_W)
   ) u_prio (
      .pend      ({snes_busy_q & ~snes_issued, bus.dcmp_req, bus.mcu_req}),
      .burst_cnt (burst_cnt),
      .owner     (pick)
   );

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick != OWN_NONE) begin
               grant     = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         wait_cnt   <= '0;
         burst_cnt  <= '0;
         mem_addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner <= pick;
            case (pick)
               OWN_SNES: mem_addr_q <= snes_pend_addr;
               OWN_DCMP: mem_addr_q <= bus.dcmp_addr;
               default:  mem_addr_q <= bus.mcu_addr;
            endcase
         end
         if (state == ST_ISSUE)
            wait_cnt <= WAIT_W'(RD_CYCLES - 1);
         else if ((state == ST_WAIT) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - WAIT_W'(1);
         // SNES grants leave the decompressor burst allowance untouched.
         if (state == ST_IDLE) begin
            if (pick == OWN_DCMP) begin
               if (burst_cnt != BURST_W'(DCMP_BURST_MAX))
                  burst_cnt <= burst_cnt + BURST_W'(1);
            end else if ((pick == OWN_MCU) || (pick == OWN_NONE)) begin
               burst_cnt <= '0;
            end
         end
      end
   end

   // A new snes_rd always wins over completion of an already-issued old read.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         snes_pend_addr <= '0;
         snes_busy_q    <= 1'b0;
         snes_issued    <= 1'b0;
         snes_overrun_q <= 1'b0;
      end else begin
         if (bus.snes_rd) begin
            snes_pend_addr <= bus.snes_addr;
            snes_busy_q    <= 1'b1;
            snes_issued    <= 1'b0;
            if (snes_busy_q)
               snes_overrun_q <= 1'b1;
         end else if (grant && (pick == OWN_SNES)) begin
            snes_issued <= 1'b1;
         end else if (capture && (owner == OWN_SNES) && snes_issued) begin
            snes_busy_q <= 1'b0;
            snes_issued <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         snes_data_q <= '0;
         dcmp_data_q <= '0;
         mcu_data_q  <= '0;
      end else if (capture) begin
         case (owner)
            OWN_SNES: snes_data_q <= bus.mem_data_in;
            OWN_DCMP: dcmp_data_q <= bus.mem_data_in;
            OWN_MCU:  mcu_data_q  <= bus.mem_data_in;
            default:  ;
         endcase
      end
   end

   assign bus.mem_rd       = (state == ST_ISSUE);
   assign bus.mem_addr     = mem_addr_q;
   assign bus.dcmp_ack     = (state == ST_DONE) && (owner == OWN_DCMP);
   assign bus.mcu_ack      = (state == ST_DONE) && (owner == OWN_MCU);
   assign bus.dcmp_data    = dcmp_data_q;
   assign bus.mcu_data     = mcu_data_q;
   assign bus.snes_data    = snes_data_q;
   assign bus.snes_busy    = snes_busy_q;
   assign bus.snes_overrun = snes_overrun_q;

endmodule

// File: tb/tb_spc7110_rom_arbiter.sv
// Bench for spc7110_rom_arbiter: a PSRAM model with fixed read latency and
// per-requester scoreboards of expected read data.
module tb_spc7110_rom_arbiter;

   localparam int RD   = 4;
   localparam int BMAX = 4;
   localparam int TMO  = 60;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int mcu_acks = 0;

   logic [7:0]  dcmp_q[$];
   logic [7:0]  mcu_q[$];
   logic [1:0]  ack_log[$];
   int          rd_cyc[$];
   logic [23:0] rd_addr[$];

   logic        slot_v[0:RD];
   logic [23:0] slot_a[0:RD];

   spc7110_rom_arbiter_if #(.ADDR_W(24)) bus();

   spc7110_rom_arbiter #(
      .ADDR_W         (24),
      .RD_CYCLES      (RD),
      .DCMP_BURST_MAX (BMAX)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // PSRAM model: data for a read appears exactly RD cycles after mem_rd.
   initial begin
      for (int i = 0; i <= RD; i++) begin
         slot_v[i] = 1'b0;
         slot_a[i] = '0;
      end
      bus.mem_data_in = 8'hEE;
      forever begin
         @(negedge CLK);
         for (int i = RD; i > 0; i--) begin
            slot_v[i] = slot_v[i-1];
            slot_a[i] = slot_a[i-1];
         end
         slot_v[0] = bus.mem_rd;
         slot_a[0] = bus.mem_addr;
         bus.mem_data_in = slot_v[RD] ? rom_byte(slot_a[RD]) : 8'hEE;
      end
   end

   // Output monitor: ack data against the scoreboards, plus read-issue log.
   initial begin
      forever begin
         @(negedge CLK);
         if (bus.mem_rd) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(bus.mem_addr);
         end
         if (bus.dcmp_ack) begin
            ack_log.push_back(2'd2);
            if (dcmp_q.size() == 0) check_eq("dcmp_ack_unexpected", 1, 0);
            else check_eq("dcmp_data", bus.dcmp_data, dcmp_q.pop_front());
         end
         if (bus.mcu_ack) begin
            ack_log.push_back(2'd3);
            mcu_acks++;
            if (mcu_q.size() == 0) check_eq("mcu_ack_unexpected", 1, 0);
            else check_eq("mcu_data", bus.mcu_data, mcu_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic dcmp_read(input logic [23:0] a);
      int n = 0;
      bus.dcmp_req  = 1'b1;
      bus.dcmp_addr = a;
      dcmp_q.push_back(rom_byte(a));
      do begin
         @(negedge CLK);
         n++;
      end while (!bus.dcmp_ack && n < TMO);
      if (!bus.dcmp_ack) check_eq("dcmp_timeout", 0, 1);
      bus.dcmp_req = 1'b0;
   endtask

   task automatic mcu_read(input logic [23:0] a);
      int n = 0;
      bus.mcu_req  = 1'b1;
      bus.mcu_addr = a;
      mcu_q.push_back(rom_byte(a));
      do begin
         @(negedge CLK);
         n++;
      end while (!bus.mcu_ack && n < TMO);
      if (!bus.mcu_ack) check_eq("mcu_timeout", 0, 1);
      bus.mcu_req = 1'b0;
   endtask

   task automatic snes_pulse(input logic [23:0] a);
      bus.snes_rd   = 1'b1;
      bus.snes_addr = a;
      @(negedge CLK);
      bus.snes_rd = 1'b0;
   endtask

   task automatic wait_snes_idle(input string tag);
      int n = 0;
      while (bus.snes_busy && n < TMO) begin
         @(negedge CLK);
         n++;
      end
      if (bus.snes_busy) check_eq(tag, 0, 1);
   endtask

   initial begin
      logic [1:0] exp_log[7];
      exp_log = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2};
      bus.snes_rd   = 1'b0;
      bus.snes_addr = '0;
      bus.dcmp_req  = 1'b0;
      bus.dcmp_addr = '0;
      bus.mcu_req   = 1'b0;
      bus.mcu_addr  = '0;

      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      check_eq("rst_snes_busy", bus.snes_busy, 0);
      check_eq("rst_overrun", bus.snes_overrun, 0);
      check_eq("rst_mem_rd", bus.mem_rd, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
      check_eq("rst_acks", {bus.dcmp_ack, bus.mcu_ack}, 0);
      check_eq("rst_data", {bus.snes_data, bus.dcmp_data, bus.mcu_data}, 0);

      // 1: single SNES read timing
      snes_pulse(24'h100010);
      check_eq("t1_busy_set", bus.snes_busy, 1);
      check_eq("t1_no_early_rd", bus.mem_rd, 0);
      @(negedge CLK);
      check_eq("t1_mem_rd", bus.mem_rd, 1);
      check_eq("t1_mem_addr", bus.mem_addr, 24'h100010);
      repeat (4) @(negedge CLK);
      check_eq("t1_busy_hold", bus.snes_busy, 1);
      @(negedge CLK);
      check_eq("t1_busy_clr", bus.snes_busy, 0);
      check_eq("t1_snes_data", bus.snes_data, 8'hA5);
      repeat (3) @(negedge CLK);

      // 6: lone decompressor stream, mem_rd spacing
      rd_cyc.delete();
      dcmp_read(24'h200000);
      dcmp_read(24'h200001);
      dcmp_read(24'h200002);
      check_eq("t6_rd_count", rd_cyc.size(), 3);
      if (rd_cyc.size() == 3) begin
         check_eq("t6_gap0", rd_cyc[1] - rd_cyc[0], RD + 3);
         check_eq("t6_gap1", rd_cyc[2] - rd_cyc[1], RD + 3);
      end
      repeat (3) @(negedge CLK);

      // 2: decompressor burst vs MCU
      ack_log.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) dcmp_read(24'h300000 + 24'(i));
         end
         mcu_read(24'h400123);
      join
      check_eq("t2_ack_count", ack_log.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < ack_log.size()) check_eq($sformatf("t2_order%0d", i), ack_log[i], exp_log[i]);
      repeat (3) @(negedge CLK);

      // 3: SNES read arriving during a decompressor WAIT
      rd_addr.delete();
      fork
         begin
            dcmp_read(24'h500010);
            dcmp_read(24'h500011);
         end
         begin
            repeat (4) @(negedge CLK);
            snes_pulse(24'h123456);
            wait_snes_idle("t3_snes_timeout");
            check_eq("t3_snes_data", bus.snes_data, rom_byte(24'h123456));
         end
      join
      check_eq("t3_rd_count", rd_addr.size(), 3);
      if (rd_addr.size() == 3) begin
         check_eq("t3_rd0", rd_addr[0], 24'h500010);
         check_eq("t3_rd1", rd_addr[1], 24'h123456);
         check_eq("t3_rd2", rd_addr[2], 24'h500011);
      end
      check_eq("t3_no_overrun", bus.snes_overrun, 0);
      repeat (3) @(negedge CLK);

      // 4: SNES overrun, latest address wins
      rd_addr.delete();
      snes_pulse(24'h100000);
      snes_pulse(24'h100001);
      check_eq("t4_overrun", bus.snes_overrun, 1);
      wait_snes_idle("t4_snes_timeout");
      check_eq("t4_snes_data", bus.snes_data, 8'hB4);
      check_eq("t4_rd_count", rd_addr.size(), 2);
      if (rd_addr.size() == 2) check_eq("t4_rd1", rd_addr[1], 24'h100001);
      repeat (3) @(negedge CLK);
      check_eq("t4_overrun_sticky", bus.snes_overrun, 1);

      // 5: reset during an MCU read WAIT
      begin
         int acks_before;
         acks_before  = mcu_acks;
         bus.mcu_req  = 1'b1;
         bus.mcu_addr = 24'h600077;
         repeat (4) @(negedge CLK);
         RESET = 1'b1;
         #1;
         check_eq("t5_rst_busy_ovr", {bus.snes_busy, bus.snes_overrun}, 0);
         check_eq("t5_rst_mem", {bus.mem_rd, bus.mem_addr}, 0);
         check_eq("t5_rst_data", {bus.snes_data, bus.dcmp_data, bus.mcu_data}, 0);
         check_eq("t5_rst_acks", {bus.dcmp_ack, bus.mcu_ack}, 0);
         bus.mcu_req = 1'b0;
         @(negedge CLK);
         RESET = 1'b0;
         repeat (10) @(negedge CLK);
         check_eq("t5_no_mcu_ack", mcu_acks - acks_before, 0);
         mcu_read(24'h600078);
         check_eq("t5_mcu_served", mcu_acks - acks_before, 1);
      end
      repeat (3) @(negedge CLK);
      check_eq("end_dcmp_q_empty", dcmp_q.size(), 0);
      check_eq("end_mcu_q_empty", mcu_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
